// File: rtl/cp0_regfile_if.sv
// Pipeline <-> CP0 bundle: exception commit, ERET, MTC0/MFC0 access and the PC redirect.
interface cp0_regfile_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        is_eret;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_badvaddr,
    output is_eret, wen, waddr, wdata, raddr,
    input  rdata, redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_code, exc_pc, exc_in_delay_slot, exc_badvaddr,
    input  is_eret, wen, waddr, wdata, raddr,
    output rdata, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC with exception/ERET commit.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt.
module cp0_regfile #(
  parameter logic [31:0] EXC_ENTRY    = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   ext_int,
  cp0_regfile_if.slave bus,
  output logic [31:0]  cp0_status,
  output logic [7:0]   interrupt_info
);

  localparam logic [4:0]  REG_BADVADDR = 5'd8;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [4:0]  EXC_ADES     = 5'd5;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;  // IM[15:8], EXL, IE

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic        tick;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic        timer_pending;
  logic        timer_pending_next;
  logic [31:0] compare_val;
  logic [31:0] cause;
  logic [31:0] count_next;

  logic do_exc, do_eret, do_mtc0, wr_count;

  assign do_exc   = bus.exc_valid;
  assign do_eret  = bus.is_eret & ~bus.exc_valid;
  assign do_mtc0  = bus.wen & ~bus.exc_valid & ~bus.is_eret;
  assign wr_count = do_mtc0 && (bus.waddr == REG_COUNT);

  // A Count load replaces that cycle's increment; tick keeps toggling regardless.
  assign count_next = wr_count ? bus.wdata : count + {31'd0, tick};

`ifdef CP0_TIMER_INT_EN
  logic [31:0] compare;
  logic        wr_compare;
  logic        count_upd;

  assign wr_compare  = do_mtc0 && (bus.waddr == REG_COMPARE);
  assign count_upd   = wr_count | tick;
  assign compare_val = compare;
  // Only a Count that actually moves onto Compare raises the interrupt, so an idle
  // Count sitting at Compare does not re-arm it right after a Compare write.
  assign timer_pending_next = wr_compare ? 1'b0
                            : (timer_pending | (count_upd && (count_next == compare)));

  always_ff @(posedge clk) begin
    if (reset) begin
      compare       <= '0;
      timer_pending <= 1'b0;
    end else begin
      timer_pending <= timer_pending_next;
      if (wr_compare) compare <= bus.wdata;
    end
  end
`else
  assign compare_val        = '0;
  assign timer_pending      = 1'b0;
  assign timer_pending_next = 1'b0;
`endif

  assign cause = {cause_bd, timer_pending, 14'd0, cause_ip_hw, cause_ip_sw,
                  1'b0, cause_exc, 2'b00};

  assign cp0_status     = status;
  assign interrupt_info = cause[15:8] & status[15:8];

  assign bus.redirect_valid = do_exc | do_eret;
  assign bus.redirect_pc    = do_exc ? EXC_ENTRY : (do_eret ? epc : 32'd0);

  always_comb begin
    bus.rdata = '0;
    case (bus.raddr)
      REG_BADVADDR: bus.rdata = badvaddr;
      REG_COUNT:    bus.rdata = count;
      REG_COMPARE:  bus.rdata = compare_val;
      REG_STATUS:   bus.rdata = status;
      REG_CAUSE:    bus.rdata = cause;
      REG_EPC:      bus.rdata = epc;
      default:      bus.rdata = '0;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
  always_ff @(posedge clk) begin
    if (reset) begin
      status      <= STATUS_RESET;
      epc         <= '0;
      badvaddr    <= '0;
      count       <= '0;
      tick        <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_hw <= '0;
      cause_ip_sw <= '0;
      cause_exc   <= '0;
    end else begin
      tick        <= ~tick;
      count       <= count_next;
      cause_ip_hw <= {ext_int[5] | timer_pending_next, ext_int[4:0]};

      if (do_exc) begin
        cause_exc <= bus.exc_code;
        status[1] <= 1'b1;
        // A nested exception keeps the EPC/BD of the original one.
        if (!status[1]) begin
          epc      <= bus.exc_in_delay_slot ? bus.exc_pc - 32'd4 : bus.exc_pc;
          cause_bd <= bus.exc_in_delay_slot;
        end
        if (bus.exc_code == EXC_ADEL || bus.exc_code == EXC_ADES)
          badvaddr <= bus.exc_badvaddr;
      end else if (do_eret) begin
        status[1] <= 1'b0;
      end else if (do_mtc0) begin
        case (bus.waddr)
          REG_STATUS: status      <= (status & ~STATUS_WMASK) | (bus.wdata & STATUS_WMASK);
          REG_CAUSE:  cause_ip_sw <= bus.wdata[9:8];
          REG_EPC:    epc         <= bus.wdata;
          default:    ;
        endcase
      end
    end
  end

endmodule
